// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions for the stopwatch encoder and the scan decoder.
// Segment constants are the active-low {G,F,E,D,C,B,A} patterns for digits 0..9.
// seg7_decode returns {legal, bcd[3:0]}. Unknown patterns return legal = 0.
package seg7_pkg;

  localparam logic [6:0] SEG7_0 = 7'h40;
  localparam logic [6:0] SEG7_1 = 7'h79;
  localparam logic [6:0] SEG7_2 = 7'h24;
  localparam logic [6:0] SEG7_3 = 7'h30;
  localparam logic [6:0] SEG7_4 = 7'h19;
  localparam logic [6:0] SEG7_5 = 7'h12;
  localparam logic [6:0] SEG7_6 = 7'h02;
  localparam logic [6:0] SEG7_7 = 7'h78;
  localparam logic [6:0] SEG7_8 = 7'h00;
  localparam logic [6:0] SEG7_9 = 7'h10;

  localparam logic [3:0] AN_BLANK = 4'b1111;

  function automatic logic [4:0] seg7_decode(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      SEG7_0:  res = {1'b1, 4'd0};
      SEG7_1:  res = {1'b1, 4'd1};
      SEG7_2:  res = {1'b1, 4'd2};
      SEG7_3:  res = {1'b1, 4'd3};
      SEG7_4:  res = {1'b1, 4'd4};
      SEG7_5:  res = {1'b1, 4'd5};
      SEG7_6:  res = {1'b1, 4'd6};
      SEG7_7:  res = {1'b1, 4'd7};
      SEG7_8:  res = {1'b1, 4'd8};
      SEG7_9:  res = {1'b1, 4'd9};
      default: res = 5'b0_0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seg7_dwell_filter.sv
// Settling filter for the scanned display lines.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   pins_i [11:0]  raw {AN, SEG_DP, SEG_G..SEG_A}
//   accept_o       combinational pulse: this edge accepts the settled dwell
//   vec_o  [11:0]  settled vector (equal to pins_i whenever accept_o is high)
module seg7_dwell_filter #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [11:0] pins_i,
  output logic        accept_o,
  output logic [11:0] vec_o
);

  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ACCEPT = CNT_W'(STABLE_CYCLES - 1);

  logic [11:0]      sr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic             match;

  assign match    = (pins_i == sr_q);
  // The counter counts matching edges after the first sample, so the dwell is
  // accepted on the STABLE_CYCLES-th edge of a constant input.
  assign accept_o = match && (cnt_q == CNT_ACCEPT) && !acc_q;
  assign vec_o    = sr_q;

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (match) begin
      if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
      if (accept_o)         acc_d = 1'b1;
    end else begin
      cnt_d = '0;
      acc_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q  <= '1;
      cnt_q <= '0;
      acc_q <= 1'b0;
    end else begin
      sr_q  <= pins_i;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive side of a multiplexed 4-digit seven-segment display: decodes the
// scanned lines back into four BCD digits with decimal points.
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   SEG_A..SEG_G, SEG_DP  segment lines, active-low
//   AN[3:0]               digit anodes, active-low, AN[0] = rightmost
//   DIGIT0..DIGIT3        captured BCD per digit
//   DP[3:0]               captured decimal point per digit, 1 = lit
//   DIGIT_VALID[3:0]      digit n holds a legal decode
//   FRAME_STB             pulse once all four digits were seen since the last pulse
//   SEG_ERR, AN_ERR       pulses for undecodable pattern / multiple anodes low
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SEG_A,
  input  logic       SEG_B,
  input  logic       SEG_C,
  input  logic       SEG_D,
  input  logic       SEG_E,
  input  logic       SEG_F,
  input  logic       SEG_G,
  input  logic       SEG_DP,
  input  logic [3:0] AN,
  output logic [3:0] DIGIT0,
  output logic [3:0] DIGIT1,
  output logic [3:0] DIGIT2,
  output logic [3:0] DIGIT3,
  output logic [3:0] DP,
  output logic [3:0] DIGIT_VALID,
  output logic       FRAME_STB,
  output logic       SEG_ERR,
  output logic       AN_ERR
);

  logic [11:0] pins, vec;
  logic        accept;

  logic [3:0]  digit_q [4];
  logic [3:0]  digit_d [4];
  logic [3:0]  dp_q, dp_d;
  logic [3:0]  valid_q, valid_d;
  logic [3:0]  set_q, set_d;
  logic        frame_q, frame_d;
  logic        seg_err_q, seg_err_d;
  logic        an_err_q, an_err_d;

  logic        single;
  logic [1:0]  idx;
  logic [4:0]  dec;

  assign pins = {AN, SEG_DP, SEG_G, SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A};

  seg7_dwell_filter #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_filter (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .pins_i  (pins),
    .accept_o(accept),
    .vec_o   (vec)
  );

  always_comb begin
    digit_d   = digit_q;
    dp_d      = dp_q;
    valid_d   = valid_q;
    // A full set is consumed by this edge's strobe; a same-edge acceptance
    // starts the next frame with only its own bit.
    frame_d   = (set_q == 4'b1111);
    set_d     = frame_d ? 4'b0000 : set_q;
    seg_err_d = 1'b0;
    an_err_d  = 1'b0;
    single    = 1'b0;
    idx       = 2'd0;
    dec       = '0;
    if (accept) begin
      case (vec[11:8])
        4'b1110: begin single = 1'b1; idx = 2'd0; end
        4'b1101: begin single = 1'b1; idx = 2'd1; end
        4'b1011: begin single = 1'b1; idx = 2'd2; end
        4'b0111: begin single = 1'b1; idx = 2'd3; end
        AN_BLANK: ;
        default: an_err_d = 1'b1;
      endcase
      if (single) begin
        dec        = seg7_decode(vec[6:0]);
        set_d[idx] = 1'b1;
        if (dec[4]) begin
          digit_d[idx] = dec[3:0];
          dp_d[idx]    = ~vec[7];
          valid_d[idx] = 1'b1;
        end else begin
          valid_d[idx] = 1'b0;
          seg_err_d    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      digit_q   <= '{default: '0};
      dp_q      <= '0;
      valid_q   <= '0;
      set_q     <= '0;
      frame_q   <= 1'b0;
      seg_err_q <= 1'b0;
      an_err_q  <= 1'b0;
    end else begin
      digit_q   <= digit_d;
      dp_q      <= dp_d;
      valid_q   <= valid_d;
      set_q     <= set_d;
      frame_q   <= frame_d;
      seg_err_q <= seg_err_d;
      an_err_q  <= an_err_d;
    end
  end

  assign DIGIT0      = digit_q[0];
  assign DIGIT1      = digit_q[1];
  assign DIGIT2      = digit_q[2];
  assign DIGIT3      = digit_q[3];
  assign DP          = dp_q;
  assign DIGIT_VALID = valid_q;
  assign FRAME_STB   = frame_q;
  assign SEG_ERR     = seg_err_q;
  assign AN_ERR      = an_err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder with default STABLE_CYCLES = 4.
module tb_seg7_scan_decoder;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_G, SEG_DP;
  logic [3:0] AN;
  logic [3:0] DIGIT0, DIGIT1, DIGIT2, DIGIT3, DP, DIGIT_VALID;
  logic       FRAME_STB, SEG_ERR, AN_ERR;

  int vectors     = 0;
  int miscompares = 0;
  int frame_cnt   = 0;
  int seg_err_cnt = 0;
  int an_err_cnt  = 0;
  logic saw8      = 1'b0;

  seg7_scan_decoder dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .SEG_A      (SEG_A),
    .SEG_B      (SEG_B),
    .SEG_C      (SEG_C),
    .SEG_D      (SEG_D),
    .SEG_E      (SEG_E),
    .SEG_F      (SEG_F),
    .SEG_G      (SEG_G),
    .SEG_DP     (SEG_DP),
    .AN         (AN),
    .DIGIT0     (DIGIT0),
    .DIGIT1     (DIGIT1),
    .DIGIT2     (DIGIT2),
    .DIGIT3     (DIGIT3),
    .DP         (DP),
    .DIGIT_VALID(DIGIT_VALID),
    .FRAME_STB  (FRAME_STB),
    .SEG_ERR    (SEG_ERR),
    .AN_ERR     (AN_ERR)
  );

  always #5 CLK = ~CLK;

  // Pulse counters, sampled mid-cycle.
  always @(negedge CLK) begin
    if (FRAME_STB) frame_cnt++;
    if (SEG_ERR)   seg_err_cnt++;
    if (AN_ERR)    an_err_cnt++;
    if (DIGIT0 == 4'd8) saw8 = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input logic dp_lit);
    AN = an;
    {SEG_G, SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A} = seg;
    SEG_DP = ~dp_lit;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [11:0] r;

    // Reset with random pins.
    RESET = 1'b1;
    r = 12'($urandom);
    drive(r[11:8], r[6:0], r[7]);
    tick(3);
    chk("rst_digits", {DIGIT3, DIGIT2, DIGIT1, DIGIT0}, 32'h0);
    chk("rst_dp_valid", {DP, DIGIT_VALID}, 32'h0);
    chk("rst_pulses", {FRAME_STB, SEG_ERR, AN_ERR}, 32'h0);
    drive(4'b1111, 7'h7F, 1'b0);
    RESET = 1'b0;
    tick(2);

    // Full frame, DP lit on digit 2.
    drive(4'b1110, 7'h40, 1'b0); tick(8);
    chk("frame_valid0", DIGIT_VALID, 32'b0001);
    drive(4'b1101, 7'h79, 1'b0); tick(8);
    chk("frame_d1", DIGIT1, 32'd1);
    chk("frame_valid1", DIGIT_VALID, 32'b0011);
    drive(4'b1011, 7'h24, 1'b1); tick(8);
    chk("frame_d2", DIGIT2, 32'd2);
    chk("frame_dp2", DP, 32'b0100);
    drive(4'b0111, 7'h30, 1'b0); tick(4);
    chk("frame_d3_early", {DIGIT_VALID, DIGIT3}, {24'h0, 4'b0111, 4'd0});
    tick(1);
    chk("frame_d3_accept", {DIGIT_VALID, DIGIT3}, {24'h0, 4'b1111, 4'd3});
    chk("frame_stb_same_edge", FRAME_STB, 32'd0);
    tick(1);
    chk("frame_stb_pulse", FRAME_STB, 32'd1);
    tick(1);
    chk("frame_stb_end", FRAME_STB, 32'd0);
    tick(1);
    chk("frame_count", frame_cnt, 32'd1);
    chk("frame_digits", {DIGIT3, DIGIT2, DIGIT1, DIGIT0}, 32'h3210);
    chk("frame_dp", DP, 32'b0100);

    // Latency: accept on the 5th edge after the change.
    drive(4'b1110, 7'h10, 1'b0); tick(4);
    chk("lat_before", DIGIT0, 32'd0);
    tick(1);
    chk("lat_accept", DIGIT0, 32'd9);
    tick(3);
    drive(4'b1110, 7'h12, 1'b0); tick(8);
    chk("digit0_5", DIGIT0, 32'd5);

    // Short glitch to 8 inside a dwell of 9.
    drive(4'b1110, 7'h10, 1'b0); tick(2);
    drive(4'b1110, 7'h00, 1'b0); tick(2);
    chk("glitch_ignored", DIGIT0, 32'd5);
    drive(4'b1110, 7'h10, 1'b0); tick(4);
    chk("glitch_restart", DIGIT0, 32'd5);
    tick(1);
    chk("glitch_accept9", DIGIT0, 32'd9);
    tick(3);
    chk("glitch_never8", saw8, 32'd0);

    // Illegal pattern on digit 1.
    drive(4'b1101, 7'h7F, 1'b0); tick(4);
    chk("ill_before", SEG_ERR, 32'd0);
    tick(1);
    chk("ill_seg_err", SEG_ERR, 32'd1);
    chk("ill_valid", DIGIT_VALID, 32'b1101);
    chk("ill_digit1_held", DIGIT1, 32'd1);
    tick(1);
    chk("ill_seg_err_end", SEG_ERR, 32'd0);

    // Two anodes low, then blanking.
    drive(4'b1100, 7'h40, 1'b0); tick(5);
    chk("an_err_pulse", AN_ERR, 32'd1);
    tick(1);
    chk("an_err_end", AN_ERR, 32'd0);
    chk("an_err_digits", {DIGIT_VALID, DIGIT1, DIGIT0}, {20'h0, 4'b1101, 4'd1, 4'd9});
    drive(4'b1111, 7'h7F, 1'b1); tick(10);
    chk("blank_counts", {an_err_cnt[7:0], seg_err_cnt[7:0], frame_cnt[7:0]}, 32'h010101);

    // Reset in the middle of a frame.
    drive(4'b1110, 7'h40, 1'b0); tick(8);
    drive(4'b1101, 7'h79, 1'b0); tick(8);
    chk("midrst_pre_valid", DIGIT_VALID, 32'b1111);
    RESET = 1'b1;
    drive(4'b1111, 7'h7F, 1'b1);
    tick(1);
    RESET = 1'b0;
    chk("midrst_cleared", {DIGIT_VALID, DIGIT1}, 32'h0);
    drive(4'b1011, 7'h24, 1'b0); tick(8);
    drive(4'b0111, 7'h30, 1'b0); tick(8);
    drive(4'b1111, 7'h7F, 1'b1); tick(4);
    chk("midrst_valid", DIGIT_VALID, 32'b1100);
    chk("midrst_digits", {DIGIT3, DIGIT2}, 32'h32);
    chk("midrst_no_frame", frame_cnt, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive side of the multiplexed 4-digit seven-segment interface driven by the stopwatch (SEG_A..SEG_G, SEG_DP, AN[3:0], all active-low).
- Watches the scanned display lines, waits for each digit dwell to settle, decodes the segment pattern back to BCD and holds all four digits plus their decimal points.
- Used as an in-fabric display checker and as a monitor in stopwatch-level benches.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples needed before a dwell is accepted (min 2, max 255).
- CNT_W, 8, width of the saturating stability counter.

Ports:
- CLK  input  1  system clock
- RESET  input  1  synchronous, active-high reset
- SEG_A..SEG_G  input  1 each  segment lines, active-low
- SEG_DP  input  1  decimal point, active-low
- AN  input  4  digit anodes, active-low, AN[0] = rightmost digit
- DIGIT0..DIGIT3  output  4 each  captured BCD value per digit
- DP  output  4  captured decimal point per digit, 1 = lit
- DIGIT_VALID  output  4  bit n = DIGITn holds a legal decode
- FRAME_STB  output  1  one-cycle pulse when all four digits have been captured since the previous pulse
- SEG_ERR  output  1  one-cycle pulse when an accepted dwell has an undecodable pattern
- AN_ERR  output  1  one-cycle pulse when an accepted dwell has more than one anode low

Behaviour:
- Reset: all outputs are 0, the sample register is all-ones (blank), the counter is 0 and the captured-set is 0. RESET wins over every other event. Asserting RESET mid-dwell discards the dwell.
- Sampling: every edge registers the 12-bit vector {AN, SEG_DP, SEG_G..SEG_A} into the sample register (SR).
  - If the incoming pins equal SR, the counter increments, saturating at STABLE_CYCLES.
  - Otherwise the counter clears to 0 and the accepted flag clears.
- Acceptance: a dwell is accepted once, on the edge where the counter reaches STABLE_CYCLES-1 and pins still equal SR, and only if the accepted flag is clear. Acceptance sets the flag.
  - Latency: pins constant from edge k give accept at edge k+STABLE_CYCLES.
  - The outputs update at that same edge.
- Anode classification of an accepted dwell:
  - All AN high: blanking. No update, no error.
  - Exactly one AN bit low, index n: a decode dwell.
  - Two or more low: AN_ERR pulses for 1 cycle. No digit update.
- Decode table for {G..A}, active-low hex; any other value is illegal:
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19
  - 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10
- Legal decode:
  - DIGITn gets the value, DP[n] gets ~SEG_DP, DIGIT_VALID[n] is set.
  - Bit n of the captured-set is set.
- Illegal decode:
  - SEG_ERR pulses for 1 cycle and DIGIT_VALID[n] clears.
  - DIGITn and DP[n] hold their previous values.
  - Captured-set bit n is set (the dwell was seen).
- Frame: on the cycle after the captured-set becomes 4'b1111, FRAME_STB pulses for 1 cycle and the captured-set clears.
  - If a new acceptance lands on the same edge as that clear, the set restarts holding only the new digit's bit.
- Re-capturing the same digit before the frame completes overwrites it. The captured-set is unchanged.
- Glitches shorter than STABLE_CYCLES samples are ignored entirely.

Decomposition:
- Shared package seg7_pkg holds:
  - the ten active-low segment constants (SEG7_0..SEG7_9);
  - a decode function returning {legal, bcd[3:0]};
  - the AN_BLANK constant 4'b1111.
- The stopwatch encoder reuses the same constants.
- One natural sub-module, seg7_dwell_filter, contains the sample register, the stability counter and the accept-once flag, and outputs an accept pulse with the settled vector. The top level holds anode classification, decode, digit registers and frame logic.

Test Plan:
- Reset: hold RESET 3 cycles with random pins -> all outputs 0, FRAME_STB 0.
- Full frame: drive AN=1110/SEG=40, 1101/79, 1011/24, 0111/30, 8 cycles each, DP lit on digit 2 -> DIGIT0..3 = 0,1,2,3, DP=4'b0100, DIGIT_VALID=1111, a single FRAME_STB pulse 1 cycle after the last accept.
- Latency and glitch: with STABLE_CYCLES=4, hold AN=1110/SEG=10 from edge k -> DIGIT0=9 at edge k+4. A 2-cycle SEG=00 glitch inserted mid-dwell -> no update to 8, and the accept for 9 happens only once.
- Illegal pattern: AN=1101, SEG=7F held 6 cycles -> SEG_ERR 1-cycle pulse, DIGIT_VALID[1]=0, DIGIT1 unchanged.
- Anode fault: AN=1100 held 6 cycles -> AN_ERR pulse, no digit change. AN=1111 held 10 cycles -> no pulses.
- Reset mid-frame: after capturing digits 0 and 1, assert RESET 1 cycle, then send digits 2 and 3 only -> no FRAME_STB, DIGIT_VALID=1100.
